// File: rtl/result_collector_pkg.sv
// Shared types for the result collector: FSM state encodings, read-out order, index widths.
package result_collector_pkg;

  typedef enum logic {WIdle, WCollect} w_state_e;
  typedef enum logic {RIdle, RStream} r_state_e;
  typedef enum logic {OrderRow, OrderCol} order_e;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_bank.sv
// One ROWSxCOLS tile store: writes a whole column per cycle, reads one element by index.
module result_bank
  import result_collector_pkg::*;
#(
  parameter int unsigned ROWS       = 3,
  parameter int unsigned COLS       = 3,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned RowW      = idx_width(ROWS),
  localparam int unsigned ColW      = idx_width(COLS)
) (
  input  logic                            clk_i,
  input  logic                            wr_en_i,
  input  logic [ColW-1:0]                 wr_col_i,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic [RowW-1:0]                 rd_row_i,
  input  logic [ColW-1:0]                 rd_col_i,
  output logic [DATA_WIDTH-1:0]           rd_data_o
);

  // Contents are deliberately not reset; validity is tracked by the owner.
  logic [DATA_WIDTH-1:0] r_mem [ROWS][COLS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int r = 0; r < ROWS; r++) begin
        r_mem[r][wr_col_i] <= wr_data_i[r];
      end
    end
  end

  assign rd_data_o = r_mem[rd_row_i][rd_col_i];

endmodule

// File: rtl/result_collector.sv
// Captures drained systolic-array columns into rotating tile banks and streams full tiles
// out over valid/ready, so collection of the next tile overlaps read-out of the current one.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned ROWS       = 3,
  parameter int unsigned COLS       = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS  = 2,
  localparam int unsigned BankW     = idx_width(NUM_BANKS),
  localparam int unsigned CntW      = $clog2(NUM_BANKS + 1),
  localparam int unsigned RowW      = idx_width(ROWS),
  localparam int unsigned ColW      = idx_width(COLS)
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            start_i,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [COLS-1:0]                 drain_i,
  input  logic                            col_major_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_last_o,
  output logic [BankW-1:0]                out_bank_o,
  output logic                            collecting_o,
  output logic [CntW-1:0]                 full_banks_o,
  output logic                            overflow_o
);

  localparam logic [ColW-1:0]  ColLast  = ColW'(COLS - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(ROWS - 1);
  localparam logic [BankW-1:0] BankLast = BankW'(NUM_BANKS - 1);

  w_state_e              r_wstate, w_wstate_next;
  r_state_e              r_rstate, w_rstate_next;
  order_e                r_order, w_order_next;
  logic                  r_drain_prev;
  logic [ColW-1:0]       r_wcol, w_wcol_next;
  logic [BankW-1:0]      r_wp, w_wp_next;
  logic [BankW-1:0]      r_rp, w_rp_next;
  logic [RowW-1:0]       r_row, w_row_next;
  logic [ColW-1:0]       r_col, w_col_next;
  logic [NUM_BANKS-1:0]  r_full, w_full_next;
  logic [CntW-1:0]       r_full_cnt, w_full_cnt_next;
  logic                  r_overflow;

  logic                  w_pulse, w_wr_en, w_fill, w_free, w_overflow_set, w_last;
  logic [DATA_WIDTH-1:0] w_bank_rd [NUM_BANKS];

  assign w_pulse = (|drain_i) & ~r_drain_prev;

  // Write side: arm on start_i into the bank at the write pointer, fill columns high-to-low.
  always_comb begin
    w_wstate_next  = r_wstate;
    w_wcol_next    = r_wcol;
    w_wp_next      = r_wp;
    w_wr_en        = 1'b0;
    w_fill         = 1'b0;
    w_overflow_set = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        if (start_i) begin
          if (!r_full[r_wp]) begin
            w_wstate_next = WCollect;
            w_wcol_next   = ColLast;
          end else begin
            w_overflow_set = 1'b1;
          end
        end
      end
      WCollect: begin
        if (w_pulse) begin
          w_wr_en = 1'b1;
          if (r_wcol == '0) begin
            w_fill        = 1'b1;
            w_wp_next     = (r_wp == BankLast) ? '0 : r_wp + BankW'(1);
            w_wstate_next = WIdle;
          end else begin
            w_wcol_next = r_wcol - ColW'(1);
          end
        end
      end
      default: w_wstate_next = WIdle;
    endcase
  end

  // Both orders end on element (ROWS-1, COLS-1).
  assign w_last = (r_row == RowLast) && (r_col == ColLast);

  always_comb begin
    w_rstate_next = r_rstate;
    w_order_next  = r_order;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_rp_next     = r_rp;
    w_free        = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        if (r_full[r_rp]) begin
          w_rstate_next = RStream;
          w_order_next  = col_major_i ? OrderCol : OrderRow;
          w_row_next    = '0;
          w_col_next    = '0;
        end
      end
      RStream: begin
        if (out_ready_i) begin
          if (w_last) begin
            w_free        = 1'b1;
            w_rp_next     = (r_rp == BankLast) ? '0 : r_rp + BankW'(1);
            w_rstate_next = RIdle;
          end else if (r_order == OrderRow) begin
            if (r_col == ColLast) begin
              w_col_next = '0;
              w_row_next = r_row + RowW'(1);
            end else begin
              w_col_next = r_col + ColW'(1);
            end
          end else begin
            if (r_row == RowLast) begin
              w_row_next = '0;
              w_col_next = r_col + ColW'(1);
            end else begin
              w_row_next = r_row + RowW'(1);
            end
          end
        end
      end
      default: w_rstate_next = RIdle;
    endcase
  end

  // Fill and free never target the same bank: a filling bank is empty, a freed one is full.
  always_comb begin
    w_full_next = r_full;
    if (w_fill) w_full_next[r_wp] = 1'b1;
    if (w_free) w_full_next[r_rp] = 1'b0;
    w_full_cnt_next = r_full_cnt + CntW'(w_fill) - CntW'(w_free);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wstate     <= WIdle;
      r_rstate     <= RIdle;
      r_order      <= OrderRow;
      r_drain_prev <= 1'b0;
      r_wcol       <= ColLast;
      r_wp         <= '0;
      r_rp         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_full       <= '0;
      r_full_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wstate     <= w_wstate_next;
      r_rstate     <= w_rstate_next;
      r_order      <= w_order_next;
      r_drain_prev <= |drain_i;
      r_wcol       <= w_wcol_next;
      r_wp         <= w_wp_next;
      r_rp         <= w_rp_next;
      r_row        <= w_row_next;
      r_col        <= w_col_next;
      r_full       <= w_full_next;
      r_full_cnt   <= w_full_cnt_next;
      r_overflow   <= r_overflow | w_overflow_set;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    result_bank #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk_i     (clk_i),
      .wr_en_i   (w_wr_en && (r_wp == BankW'(b))),
      .wr_col_i  (r_wcol),
      .wr_data_i (data_i),
      .rd_row_i  (r_row),
      .rd_col_i  (r_col),
      .rd_data_o (w_bank_rd[b])
    );
  end

  assign out_valid_o  = (r_rstate == RStream);
  assign out_data_o   = out_valid_o ? w_bank_rd[r_rp] : '0;
  assign out_last_o   = out_valid_o & w_last;
  assign out_bank_o   = r_rp;
  assign collecting_o = (r_wstate == WCollect);
  assign full_banks_o = r_full_cnt;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_result_collector.sv
// Directed-random bench for result_collector with a tile-queue reference model.
module tb_result_collector;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned NB   = 2;
  localparam int unsigned N    = ROWS * COLS;

  typedef logic [DW-1:0] tile_t [ROWS][COLS];

  logic                    clk_i = 1'b0;
  logic                    rstn_i = 1'b0;
  logic                    start_i = 1'b0;
  logic [ROWS-1:0][DW-1:0] data_i = '0;
  logic [COLS-1:0]         drain_i = '0;
  logic                    col_major_i = 1'b0;
  logic                    out_ready_i = 1'b0;
  logic [DW-1:0]           out_data_o;
  logic                    out_valid_o;
  logic                    out_last_o;
  logic [0:0]              out_bank_o;
  logic                    collecting_o;
  logic [1:0]              full_banks_o;
  logic                    overflow_o;

  int    checks = 0;
  int    failures = 0;
  int    next_bank = 0;
  tile_t cur;
  tile_t tile_a;
  tile_t tile_b;

  result_collector #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .data_i       (data_i),
    .drain_i      (drain_i),
    .col_major_i  (col_major_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_last_o   (out_last_o),
    .out_bank_o   (out_bank_o),
    .collecting_o (collecting_o),
    .full_banks_o (full_banks_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, "_data"}, 64'(out_data_o), 64'd0);
    check({tag, "_last"}, 64'(out_last_o), 64'd0);
    check({tag, "_bank"}, 64'(out_bank_o), 64'd0);
    check({tag, "_coll"}, 64'(collecting_o), 64'd0);
    check({tag, "_full"}, 64'(full_banks_o), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
  endtask

  // Asynchronous reset asserted away from the clock edge, released on a falling edge.
  task automatic do_reset(input string tag);
    rstn_i = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk_i);
    rstn_i = 1'b1;
    next_bank = 0;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // The k-th captured column lands at column first_col-k; returns right after the last capture.
  task automatic collect(input bit do_start, input int first_col, input int ncols);
    if (do_start) start_pulse();
    for (int k = 0; k < ncols; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        data_i[r] = $urandom;
        cur[r][first_col-k] = data_i[r];
      end
      drain_i = '0;
      drain_i[$urandom_range(0, COLS - 1)] = 1'b1;
      @(negedge clk_i);
      drain_i = '0;
      for (int r = 0; r < ROWS; r++) data_i[r] = $urandom;
      if (k != ncols - 1) @(negedge clk_i);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 64'(out_valid_o), 64'd1);
  endtask

  // Consumes one tile and compares every element against the expected order.
  task automatic consume(input tile_t t, input bit cm, input bit rand_ready, input string tag);
    int idx = 0;
    int cyc = 0;
    int r;
    int c;
    wait_valid({tag, "_start"});
    while (idx < N && cyc < 400) begin
      r = cm ? idx % ROWS : idx / COLS;
      c = cm ? idx / ROWS : idx % COLS;
      check({tag, "_valid"}, 64'(out_valid_o), 64'd1);
      check({tag, "_data"}, 64'(out_data_o), 64'(t[r][c]));
      check({tag, "_last"}, 64'(out_last_o), 64'(idx == N - 1));
      check({tag, "_bank"}, 64'(out_bank_o), 64'(next_bank));
      out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_ready) col_major_i = 1'($urandom_range(0, 1));
      if (out_ready_i) idx++;
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_count"}, 64'(idx), 64'(N));
    check({tag, "_gap"}, 64'(out_valid_o), 64'd0);
    next_bank = (next_bank + 1) % NB;
  endtask

  initial begin
    do_reset("rst0");

    // Row-major tile, ready held high.
    out_ready_i = 1'b1;
    col_major_i = 1'b0;
    collect(1'b1, COLS - 1, COLS);
    check("t1_full1", 64'(full_banks_o), 64'd1);
    check("t1_not_yet", 64'(out_valid_o), 64'd0);
    consume(cur, 1'b0, 1'b0, "t1");
    check("t1_full0", 64'(full_banks_o), 64'd0);

    // Column-major tile, first valid exactly one cycle after the final column write.
    col_major_i = 1'b1;
    collect(1'b1, COLS - 1, COLS);
    check("t2_early", 64'(out_valid_o), 64'd0);
    @(negedge clk_i);
    check("t2_first", 64'(out_valid_o), 64'd1);
    consume(cur, 1'b1, 1'b0, "t2");

    // Random backpressure; col_major_i wiggles mid-stream and must be ignored.
    col_major_i = 1'b1;
    collect(1'b1, COLS - 1, COLS);
    consume(cur, 1'b1, 1'b1, "t3");

    // Two tiles held back, third start overflows without touching stored data.
    do_reset("rst4");
    out_ready_i = 1'b0;
    col_major_i = 1'b0;
    collect(1'b1, COLS - 1, COLS);
    tile_a = cur;
    collect(1'b1, COLS - 1, COLS);
    tile_b = cur;
    @(negedge clk_i);
    check("t4_full2", 64'(full_banks_o), 64'd2);
    check("t4_ovf_pre", 64'(overflow_o), 64'd0);
    start_pulse();
    check("t4_ovf", 64'(overflow_o), 64'd1);
    check("t4_idle", 64'(collecting_o), 64'd0);
    collect(1'b0, COLS - 1, COLS);
    @(negedge clk_i);
    consume(tile_a, 1'b0, 1'b0, "t4a");
    check("t4_full1", 64'(full_banks_o), 64'd1);
    consume(tile_b, 1'b0, 1'b0, "t4b");
    check("t4_full0", 64'(full_banks_o), 64'd0);

    // Idle drains ignored; a held drain captures once.
    check("t5_ovf_sticky", 64'(overflow_o), 64'd1);
    for (int i = 0; i < 2; i++) begin
      drain_i = '1;
      @(negedge clk_i);
      drain_i = '0;
      @(negedge clk_i);
    end
    check("t5_idle", 64'(collecting_o), 64'd0);
    start_pulse();
    for (int r = 0; r < ROWS; r++) begin
      data_i[r] = $urandom;
      cur[r][COLS-1] = data_i[r];
    end
    drain_i = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      for (int r = 0; r < ROWS; r++) data_i[r] = $urandom;
    end
    check("t5_one_capture", 64'(collecting_o), 64'd1);
    drain_i = '0;
    @(negedge clk_i);
    collect(1'b0, COLS - 2, COLS - 1);
    consume(cur, 1'b0, 1'b0, "t5");

    // Reset in the middle of a collection, then a fresh full tile.
    collect(1'b1, COLS - 1, 2);
    #2;
    do_reset("rst6");
    collect(1'b1, COLS - 1, COLS);
    consume(cur, 1'b0, 1'b0, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
